// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EXE inputs and EXE/MEM outputs of the execute stage, optional forwarding under EXE_FORWARDING_EN
interface exe_stage_if #(
  parameter int LEN_ADDRESS  = 32,
  parameter int LEN_REGISTER = 32,
  parameter int LEN_STATUS   = 4
);
  logic [LEN_ADDRESS-1:0]  pc_in;
  logic [LEN_REGISTER-1:0] reg_file_out1_in;
  logic [LEN_REGISTER-1:0] reg_file_out2_in;
  logic [23:0]             signed_immediate_in;
  logic [11:0]             shift_operand_in;
  logic                    is_immediate_in;
  logic                    status_write_enable_in;
  logic [3:0]              execute_command_in;
  logic                    mem_read_in;
  logic                    mem_write_in;
  logic                    wb_enable_in;
  logic                    is_branch_in;
  logic [3:0]              dest_reg_in;
`ifdef EXE_FORWARDING_EN
  logic [1:0]              sel_src1_in;
  logic [1:0]              sel_src2_in;
  logic [LEN_REGISTER-1:0] mem_fwd_in;
  logic [LEN_REGISTER-1:0] wb_fwd_in;
`endif
  logic [LEN_STATUS-1:0]   status_reg_out;
  logic [LEN_ADDRESS-1:0]  branch_address_out;
  logic                    branch_taken_out;
  logic [LEN_REGISTER-1:0] alu_result_out;
  logic [LEN_REGISTER-1:0] store_value_out;
  logic [3:0]              dest_reg_out;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic                    wb_enable_out;

  modport master (
    output pc_in, reg_file_out1_in, reg_file_out2_in, signed_immediate_in, shift_operand_in,
           is_immediate_in, status_write_enable_in, execute_command_in, mem_read_in,
           mem_write_in, wb_enable_in, is_branch_in, dest_reg_in,
`ifdef EXE_FORWARDING_EN
           sel_src1_in, sel_src2_in, mem_fwd_in, wb_fwd_in,
`endif
    input  status_reg_out, branch_address_out, branch_taken_out, alu_result_out,
           store_value_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out
  );

  modport slave (
    input  pc_in, reg_file_out1_in, reg_file_out2_in, signed_immediate_in, shift_operand_in,
           is_immediate_in, status_write_enable_in, execute_command_in, mem_read_in,
           mem_write_in, wb_enable_in, is_branch_in, dest_reg_in,
`ifdef EXE_FORWARDING_EN
           sel_src1_in, sel_src2_in, mem_fwd_in, wb_fwd_in,
`endif
    output status_reg_out, branch_address_out, branch_taken_out, alu_result_out,
           store_value_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: Val2 generation, ALU, NZCV register, branch target and EXE/MEM register; EXE_FORWARDING_EN adds operand forwarding
module exe_stage #(
  parameter int LEN_ADDRESS  = 32,
  parameter int LEN_REGISTER = 32,
  parameter int LEN_STATUS   = 4
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam int         MSB    = LEN_REGISTER - 1;

  logic [LEN_REGISTER-1:0] op_a, op_m, imm_rot, rm_asr, rm_shift, val2, b_add, result;
  logic [LEN_REGISTER:0]   sum;
  logic [4:0]              amt;
  logic                    cin, is_sub, is_arith, is_valid, ovf;
  logic [LEN_STATUS-1:0]   flags, status_d, status_q;
  logic [LEN_REGISTER-1:0] alu_result_d, alu_result_q, store_value_d, store_value_q;
  logic [3:0]              dest_reg_d, dest_reg_q;
  logic                    mem_read_d, mem_read_q, mem_write_d, mem_write_q, wb_enable_d, wb_enable_q;

  function automatic logic [LEN_REGISTER-1:0] ror(input logic [LEN_REGISTER-1:0] x, input logic [4:0] n);
    return n == 5'd0 ? x : (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // Operand sources: register file, or forwarded MEM/WB values when enabled
`ifdef EXE_FORWARDING_EN
  always_comb begin
    op_a = bus.sel_src1_in == 2'b01 ? bus.mem_fwd_in :
           bus.sel_src1_in == 2'b10 ? bus.wb_fwd_in : bus.reg_file_out1_in;
    op_m = bus.sel_src2_in == 2'b01 ? bus.mem_fwd_in :
           bus.sel_src2_in == 2'b10 ? bus.wb_fwd_in : bus.reg_file_out2_in;
  end
`else
  always_comb begin
    op_a = bus.reg_file_out1_in;
    op_m = bus.reg_file_out2_in;
  end
`endif

  // Val2: memory offset, rotated immediate, or shifted Rm
  always_comb begin
    amt      = bus.shift_operand_in[11:7];
    imm_rot  = ror({{(LEN_REGISTER-8){1'b0}}, bus.shift_operand_in[7:0]}, {bus.shift_operand_in[11:8], 1'b0});
    rm_asr   = $signed(op_m) >>> amt;
    rm_shift = bus.shift_operand_in[6:5] == 2'b00 ? op_m << amt :
               bus.shift_operand_in[6:5] == 2'b01 ? op_m >> amt :
               bus.shift_operand_in[6:5] == 2'b10 ? rm_asr : ror(op_m, amt);
    val2     = (bus.mem_read_in || bus.mem_write_in) ? {{(LEN_REGISTER-12){1'b0}}, bus.shift_operand_in} :
               bus.is_immediate_in ? imm_rot : rm_shift;
  end

  // ALU: subtracts run through the adder as A + ~B + carry-in
  always_comb begin
    is_sub   = bus.execute_command_in == OP_SUB || bus.execute_command_in == OP_SBC;
    is_arith = is_sub || bus.execute_command_in == OP_ADD || bus.execute_command_in == OP_ADC;
    is_valid = is_arith || bus.execute_command_in == OP_MOV || bus.execute_command_in == OP_MVN ||
               bus.execute_command_in == OP_AND || bus.execute_command_in == OP_ORR ||
               bus.execute_command_in == OP_EOR;
    cin      = bus.execute_command_in == OP_SUB ? 1'b1 :
               (bus.execute_command_in == OP_ADC || bus.execute_command_in == OP_SBC) ? status_q[1] : 1'b0;
    b_add    = is_sub ? ~val2 : val2;
    sum      = {1'b0, op_a} + {1'b0, b_add} + {{LEN_REGISTER{1'b0}}, cin};
    ovf      = (op_a[MSB] == b_add[MSB]) && (sum[MSB] != op_a[MSB]);
    result   = is_arith ? sum[MSB:0] :
               bus.execute_command_in == OP_MOV ? val2 :
               bus.execute_command_in == OP_MVN ? ~val2 :
               bus.execute_command_in == OP_AND ? op_a & val2 :
               bus.execute_command_in == OP_ORR ? op_a | val2 :
               bus.execute_command_in == OP_EOR ? op_a ^ val2 : '0;
    flags    = {result[MSB], result == '0, is_arith ? sum[LEN_REGISTER] : status_q[1], is_arith ? ovf : status_q[0]};
  end

  // Next-state for NZCV and the EXE/MEM register
  always_comb begin
    status_d      = (bus.status_write_enable_in && is_valid) ? flags : status_q;
    alu_result_d  = result;
    store_value_d = op_m;
    dest_reg_d    = bus.dest_reg_in;
    mem_read_d    = bus.mem_read_in;
    mem_write_d   = bus.mem_write_in;
    wb_enable_d   = bus.wb_enable_in;
  end

  // Pipeline and status state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q      <= '0;
      alu_result_q  <= '0;
      store_value_q <= '0;
      dest_reg_q    <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      wb_enable_q   <= 1'b0;
    end else begin
      status_q      <= status_d;
      alu_result_q  <= alu_result_d;
      store_value_q <= store_value_d;
      dest_reg_q    <= dest_reg_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      wb_enable_q   <= wb_enable_d;
    end
  end

  // Outputs: registered results plus same-cycle branch target
  always_comb begin
    bus.status_reg_out     = status_q;
    bus.alu_result_out     = alu_result_q;
    bus.store_value_out    = store_value_q;
    bus.dest_reg_out       = dest_reg_q;
    bus.mem_read_out       = mem_read_q;
    bus.mem_write_out      = mem_write_q;
    bus.wb_enable_out      = wb_enable_q;
    bus.branch_taken_out   = bus.is_branch_in;
    bus.branch_address_out = bus.pc_in + {{(LEN_ADDRESS-26){bus.signed_immediate_in[23]}}, bus.signed_immediate_in, 2'b00};
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vector table plus reset and forwarding sequences for exe_stage
module tb_exe_stage;
  typedef struct {
    logic [3:0]  cmd;
    logic        s, i, mr, mw, wb, br;
    logic [3:0]  dest;
    logic [31:0] rn, rm;
    logic [11:0] sh;
    logic [31:0] pc;
    logic [23:0] imm;
    logic [31:0] res;
    logic [3:0]  st;
    logic [31:0] ba;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t v[23];
  vec_t t;

  exe_stage_if bus();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h want %h", idx, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    bus.execute_command_in     = x.cmd;
    bus.status_write_enable_in = x.s;
    bus.is_immediate_in        = x.i;
    bus.mem_read_in            = x.mr;
    bus.mem_write_in           = x.mw;
    bus.wb_enable_in           = x.wb;
    bus.is_branch_in           = x.br;
    bus.dest_reg_in            = x.dest;
    bus.reg_file_out1_in       = x.rn;
    bus.reg_file_out2_in       = x.rm;
    bus.shift_operand_in       = x.sh;
    bus.pc_in                  = x.pc;
    bus.signed_immediate_in    = x.imm;
  endtask

  task automatic chk_regs(input int idx, input vec_t x);
    chk(idx, "alu_result", bus.alu_result_out, x.res);
    chk(idx, "status", 32'(bus.status_reg_out), 32'(x.st));
    chk(idx, "store_value", bus.store_value_out, x.rm);
    chk(idx, "dest_reg", 32'(bus.dest_reg_out), 32'(x.dest));
    chk(idx, "mem_read", 32'(bus.mem_read_out), 32'(x.mr));
    chk(idx, "mem_write", 32'(bus.mem_write_out), 32'(x.mw));
    chk(idx, "wb_enable", 32'(bus.wb_enable_out), 32'(x.wb));
  endtask

  task automatic chk_zero(input int idx);
    chk(idx, "rst alu_result", bus.alu_result_out, 32'h0);
    chk(idx, "rst status", 32'(bus.status_reg_out), 32'h0);
    chk(idx, "rst store_value", bus.store_value_out, 32'h0);
    chk(idx, "rst dest_reg", 32'(bus.dest_reg_out), 32'h0);
    chk(idx, "rst ctrl", 32'({bus.mem_read_out, bus.mem_write_out, bus.wb_enable_out}), 32'h0);
  endtask

  initial begin
    //          cmd    s     i     mr    mw    wb    br    dest   rn            rm            sh       pc          imm         res           st       ba
    v[0]  = '{4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 32'h7FFFFFFF, 32'h0,        12'h001, 32'h0,     24'h0,      32'h80000000, 4'b1001, 32'h0};
    v[1]  = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'd5,        32'h0,        12'h005, 32'h0,     24'h0,      32'h0,        4'b0110, 32'h0};
    v[2]  = '{4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'd1,        32'h0,        12'h001, 32'h0,     24'h0,      32'd3,        4'b0110, 32'h0};
    v[3]  = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 32'h0,        32'h0,        12'h4FF, 32'h0,     24'h0,      32'hFF000000, 4'b0110, 32'h0};
    v[4]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 32'h0,        32'h80000000, 12'h240, 32'h0,     24'h0,      32'hF8000000, 4'b0110, 32'h0};
    v[5]  = '{4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 32'h1000,     32'h0,        12'hFFC, 32'h0,     24'h0,      32'h1FFC,     4'b0110, 32'h0};
    v[6]  = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 32'h2000,     32'hDEADBEEF, 12'h004, 32'h0,     24'h0,      32'h2004,     4'b0110, 32'h0};
    v[7]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0,        32'h0,        12'h000, 32'h100,   24'hFFFFFE, 32'h0,        4'b0110, 32'hF8};
    v[8]  = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 32'd10,       32'd3,        12'h000, 32'h0,     24'h0,      32'd7,        4'b0010, 32'h0};
    v[9]  = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 32'd3,        32'h0,        12'h005, 32'h0,     24'h0,      32'hFFFFFFFE, 4'b1000, 32'h0};
    v[10] = '{4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 32'd10,       32'h0,        12'h003, 32'h0,     24'h0,      32'd6,        4'b0010, 32'h0};
    v[11] = '{4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 32'h0000F0F0, 32'h0,        12'h0FF, 32'h0,     24'h0,      32'hF0,       4'b0010, 32'h0};
    v[12] = '{4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 32'hF00,      32'h0,        12'h00F, 32'h0,     24'h0,      32'hF0F,      4'b0010, 32'h0};
    v[13] = '{4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hD, 32'hFFFFFFFF, 32'h0,        12'h0FF, 32'h0,     24'h0,      32'hFFFFFF00, 4'b1010, 32'h0};
    v[14] = '{4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 32'h0,        32'h0,        12'h000, 32'h0,     24'h0,      32'hFFFFFFFF, 4'b1010, 32'h0};
    v[15] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0,        32'h80000000, 12'hFA0, 32'h0,     24'h0,      32'h1,        4'b1010, 32'h0};
    v[16] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 32'h0,        32'hF1,       12'h260, 32'h0,     24'h0,      32'h1000000F, 4'b1010, 32'h0};
    v[17] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'h0,        32'h1,        12'hF80, 32'h0,     24'h0,      32'h80000000, 4'b1010, 32'h0};
    v[18] = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'd5,        32'h0,        12'h001, 32'h0,     24'h0,      32'h0,        4'b1010, 32'h0};
    v[19] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        12'h000, 32'h0,     24'h0,      32'h0,        4'b1010, 32'h0};
    v[20] = '{4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 32'hFFFFFFFF, 32'h0,        12'h001, 32'h0,     24'h0,      32'h0,        4'b0110, 32'h0};
    v[21] = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 32'h80000000, 32'h0,        12'h001, 32'h0,     24'h0,      32'h7FFFFFFF, 4'b0011, 32'h0};
    v[22] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 32'h0,        32'h12345678, 12'h060, 32'h0,     24'h0,      32'h12345678, 4'b0011, 32'h0};
`ifdef EXE_FORWARDING_EN
    bus.sel_src1_in = 2'b00;
    bus.sel_src2_in = 2'b00;
    bus.mem_fwd_in  = 32'h0;
    bus.wb_fwd_in   = 32'h0;
`endif
    apply(v[0]);
    #3;
    chk_zero(100);
    @(posedge clk);
    #1;
    chk_zero(101);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      apply(v[k]);
      #1;
      chk(k, "branch_address", bus.branch_address_out, v[k].ba);
      chk(k, "branch_taken", 32'(bus.branch_taken_out), 32'(v[k].br));
      @(posedge clk);
      #1;
      chk_regs(k, v[k]);
    end
    @(negedge clk);
    apply(v[0]);
    @(posedge clk);
    #1;
    chk_regs(200, v[0]);
    #2;
    rst = 1'b1;
    #1;
    chk_zero(201);
    @(negedge clk);
    rst = 1'b0;
    t = '{4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 32'd1, 32'h0, 12'h001, 32'h0, 24'h0, 32'd2, 4'b0000, 32'h0};
    apply(t);
    @(posedge clk);
    #1;
    chk_regs(202, t);
`ifdef EXE_FORWARDING_EN
    @(negedge clk);
    t = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 32'd99, 32'h55, 12'h005, 32'h0, 24'h0, 32'd15, 4'b0000, 32'h0};
    apply(t);
    bus.sel_src1_in = 2'b01;
    bus.mem_fwd_in  = 32'd10;
    bus.sel_src2_in = 2'b10;
    bus.wb_fwd_in   = 32'hABCD;
    @(posedge clk);
    #1;
    chk(300, "fwd alu_result", bus.alu_result_out, 32'd15);
    chk(300, "fwd store_value", bus.store_value_out, 32'hABCD);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
